// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if
//   Bundle between the decode/controller side and the hazard sequencer.
//   master: drives the decoded ID fields, the EX branch outcome and resume,
//           and receives the stall/flush/bypass controls and statistics.
//   slave : the hazard unit itself.
//   Signals
//     id_rs, id_rt          rs/rt fields of the ID instruction
//     id_use_rs, id_use_rt  ID instruction reads rs / rt
//     id_wr_en, id_wr_reg   ID instruction writes id_wr_reg
//     id_is_load            ID instruction is a load
//     id_syscall            ID instruction is a halting syscall
//     ex_br_taken           branch/jump in EX resolved taken
//     resume                leave HALTED
//     stall_pc, stall_ifid  hold PC / IF/ID
//     flush_ifid            clear IF/ID to a nop
//     flush_idex            load a bubble into ID/EX
//     fwd_a, fwd_b          bypass selects (0 regfile, 1 EX, 2 MEM, 3 WB)
//     halted                sequencer is in HALTED
//     stall_cnt, flush_cnt  saturating load-use stall / branch flush counts
// ---------------------------------------------------------------------------
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_wr_en;
   logic [4:0]       id_wr_reg;
   logic             id_is_load;
   logic             id_syscall;
   logic             ex_br_taken;
   logic             resume;
   logic             stall_pc;
   logic             stall_ifid;
   logic             flush_ifid;
   logic             flush_idex;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
             id_is_load, id_syscall, ex_br_taken, resume,
      input  stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
             id_is_load, id_syscall, ex_br_taken, resume,
      output stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Hazard and redirect sequencer for a 5-stage MIPS pipeline. Tracks a
//   shadow of the destination register held in EX, MEM and WB, and from it
//   produces bypass selects, load-use stalls, branch flushes and a
//   syscall drain/halt sequence.
//   Ports
//     clk    clock, rising edge
//     rst    asynchronous active-high reset
//     hz_io  hazard_if slave: ID fields and branch outcome in,
//            pipeline enables/clears, bypass selects and counters out
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic     clk,
   input  logic     rst,
   hazard_if.slave  hz_io
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       drain_q, drain_d;

   // Only the EX slot needs is_load; MEM/WB slots feed forwarding only.
   logic             ex_v_q, ex_v_d;
   logic [4:0]       ex_reg_q, ex_reg_d;
   logic             ex_ld_q, ex_ld_d;
   logic             mem_v_q;
   logic [4:0]       mem_reg_q;
   logic             wb_v_q;
   logic [4:0]       wb_reg_q;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             luse;
   logic             hold;
   logic             flush_if;
   logic             bubble;

   // Youngest matching valid slot wins; register 0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic       use_r,
      input logic [4:0] r,
      input logic       ev, input logic [4:0] er,
      input logic       mv, input logic [4:0] mr,
      input logic       wv, input logic [4:0] wr
   );
      if (!use_r || r == 5'd0) return 2'd0;
      if (ev && er == r)       return 2'd1;
      if (mv && mr == r)       return 2'd2;
      if (wv && wr == r)       return 2'd3;
      return 2'd0;
   endfunction

   always_comb begin
      luse = (state_q == ST_RUN) && ex_v_q && ex_ld_q &&
             ((hz_io.id_use_rs && hz_io.id_rs != 5'd0 && hz_io.id_rs == ex_reg_q) ||
              (hz_io.id_use_rt && hz_io.id_rt != 5'd0 && hz_io.id_rt == ex_reg_q));

      hold     = 1'b0;
      flush_if = 1'b0;
      bubble   = 1'b0;
      state_d  = state_q;
      drain_d  = drain_q;

      // A taken branch overrides every hold: the PC must take the redirect.
      if (hz_io.ex_br_taken) begin
         flush_if = 1'b1;
         bubble   = 1'b1;
      end else if (state_q != ST_RUN) begin
         hold   = 1'b1;
         bubble = 1'b1;
      end else if (luse) begin
         hold   = 1'b1;
         bubble = 1'b1;
      end else if (hz_io.id_syscall) begin
         // The syscall itself never reaches EX as a real instruction.
         bubble = 1'b1;
      end

      case (state_q)
         ST_RUN: begin
            if (hz_io.id_syscall && !hz_io.ex_br_taken && !luse) begin
               state_d = ST_DRAIN;
               drain_d = 2'd3;
            end
         end
         ST_DRAIN: begin
            // Three drain cycles let the older EX/MEM/WB work retire.
            drain_d = drain_q - 2'd1;
            if (drain_q == 2'd1) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (hz_io.resume) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      if (bubble) begin
         ex_v_d   = 1'b0;
         ex_reg_d = 5'd0;
         ex_ld_d  = 1'b0;
      end else begin
         ex_v_d   = hz_io.id_wr_en && (hz_io.id_wr_reg != 5'd0);
         ex_reg_d = hz_io.id_wr_reg;
         ex_ld_d  = hz_io.id_is_load;
      end

      stall_cnt_d = stall_cnt_q;
      if (luse && !hz_io.ex_br_taken && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + 1'b1;

      flush_cnt_d = flush_cnt_q;
      if (hz_io.ex_br_taken && flush_cnt_q != {CNT_W{1'b1}})
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         drain_q     <= 2'd0;
         ex_v_q      <= 1'b0;
         ex_reg_q    <= 5'd0;
         ex_ld_q     <= 1'b0;
         mem_v_q     <= 1'b0;
         mem_reg_q   <= 5'd0;
         wb_v_q      <= 1'b0;
         wb_reg_q    <= 5'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         ex_v_q      <= ex_v_d;
         ex_reg_q    <= ex_reg_d;
         ex_ld_q     <= ex_ld_d;
         mem_v_q     <= ex_v_q;
         mem_reg_q   <= ex_reg_q;
         wb_v_q      <= mem_v_q;
         wb_reg_q    <= mem_reg_q;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Reset dominates the combinational controls so no hold leaks through it.
   assign hz_io.stall_pc   = !rst && hold;
   assign hz_io.stall_ifid = !rst && hold;
   assign hz_io.flush_ifid = !rst && flush_if;
   assign hz_io.flush_idex = !rst && bubble;
   assign hz_io.fwd_a      = rst ? 2'd0 :
      fwd_sel(hz_io.id_use_rs, hz_io.id_rs, ex_v_q, ex_reg_q,
              mem_v_q, mem_reg_q, wb_v_q, wb_reg_q);
   assign hz_io.fwd_b      = rst ? 2'd0 :
      fwd_sel(hz_io.id_use_rt, hz_io.id_rt, ex_v_q, ex_reg_q,
              mem_v_q, mem_reg_q, wb_v_q, wb_reg_q);
   assign hz_io.halted     = (state_q == ST_HALTED);
   assign hz_io.stall_cnt  = stall_cnt_q;
   assign hz_io.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   hazard_if #(.CNT_W(CW)) hz ();

   hazard_unit #(.CNT_W(CW)) dut (
      .clk   (clk),
      .rst   (rst),
      .hz_io (hz)
   );

   always #5 clk = ~clk;

   // Reference model: list of in-flight writers, youngest first (EX, MEM, WB).
   int m_v[3];
   int m_r[3];
   int m_ld[3];
   int m_mode;   // 0 running, 1 draining, 2 halted
   int m_left;
   int m_scnt;
   int m_fcnt;

   // DUT values seen in the most recent checked cycle
   logic       o_spc, o_sif, o_fif, o_fid, o_hlt;
   logic [1:0] o_fa, o_fb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_fwd(input bit u, input int r);
      if (!u || r == 0) return 0;
      for (int i = 0; i < 3; i++)
         if (m_v[i] != 0 && m_r[i] == r) return i + 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_v[i] = 0; m_r[i] = 0; m_ld[i] = 0;
      end
      m_mode = 0; m_left = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                         input bit we, input int wr, input bit ld, input bit sys,
                         input bit br, input bit res);
      hz.id_rs = 5'(rs);      hz.id_rt = 5'(rt);
      hz.id_use_rs = urs;     hz.id_use_rt = urt;
      hz.id_wr_en = we;       hz.id_wr_reg = 5'(wr);
      hz.id_is_load = ld;     hz.id_syscall = sys;
      hz.ex_br_taken = br;    hz.resume = res;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Check one cycle against the model, then advance the model to the next edge.
   task automatic run_cycle(input string tag);
      int rs, rt, e_stall, e_fif, e_fid, hit, br, nv, nr, nl;
      @(negedge clk);
      rs = int'(hz.id_rs);
      rt = int'(hz.id_rt);
      br = int'(hz.ex_br_taken);
      hit = (m_mode == 0 && m_v[0] != 0 && m_ld[0] != 0 &&
             ((hz.id_use_rs && rs != 0 && rs == m_r[0]) ||
              (hz.id_use_rt && rt != 0 && rt == m_r[0]))) ? 1 : 0;
      e_stall = 0; e_fif = 0; e_fid = 0;
      if (br != 0) begin
         e_fif = 1; e_fid = 1;
      end else if (m_mode != 0 || hit != 0) begin
         e_stall = 1; e_fid = 1;
      end else if (hz.id_syscall) begin
         e_fid = 1;
      end
      chk({tag, ".stall_pc"},   32'(hz.stall_pc),   32'(e_stall));
      chk({tag, ".stall_ifid"}, 32'(hz.stall_ifid), 32'(e_stall));
      chk({tag, ".flush_ifid"}, 32'(hz.flush_ifid), 32'(e_fif));
      chk({tag, ".flush_idex"}, 32'(hz.flush_idex), 32'(e_fid));
      chk({tag, ".fwd_a"},      32'(hz.fwd_a),      32'(m_fwd(hz.id_use_rs, rs)));
      chk({tag, ".fwd_b"},      32'(hz.fwd_b),      32'(m_fwd(hz.id_use_rt, rt)));
      chk({tag, ".halted"},     32'(hz.halted),     32'(m_mode == 2));
      chk({tag, ".stall_cnt"},  32'(hz.stall_cnt),  32'(m_scnt));
      chk({tag, ".flush_cnt"},  32'(hz.flush_cnt),  32'(m_fcnt));
      o_spc = hz.stall_pc; o_sif = hz.stall_ifid; o_fif = hz.flush_ifid;
      o_fid = hz.flush_idex; o_fa = hz.fwd_a; o_fb = hz.fwd_b; o_hlt = hz.halted;

      if (e_fid != 0) begin
         nv = 0; nr = 0; nl = 0;
      end else begin
         nv = (hz.id_wr_en && hz.id_wr_reg != 0) ? 1 : 0;
         nr = int'(hz.id_wr_reg);
         nl = int'(hz.id_is_load);
      end
      for (int i = 2; i > 0; i--) begin
         m_v[i] = m_v[i-1]; m_r[i] = m_r[i-1]; m_ld[i] = m_ld[i-1];
      end
      m_v[0] = nv; m_r[0] = nr; m_ld[0] = nl;

      if (m_mode == 0) begin
         if (hz.id_syscall && br == 0 && hit == 0) begin
            m_mode = 1; m_left = 3;
         end
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left == 0) m_mode = 2;
      end else if (hz.resume) begin
         m_mode = 0;
      end
      if (hit != 0 && br == 0 && m_scnt < CMAX) m_scnt++;
      if (br != 0 && m_fcnt < CMAX) m_fcnt++;
      @(posedge clk);
      #1;
   endtask

   // Pulse reset mid-cycle and check everything reads zero while it is held.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      chk({tag, ".rst.stall_pc"},   32'(hz.stall_pc),   32'd0);
      chk({tag, ".rst.stall_ifid"}, 32'(hz.stall_ifid), 32'd0);
      chk({tag, ".rst.flush_ifid"}, 32'(hz.flush_ifid), 32'd0);
      chk({tag, ".rst.flush_idex"}, 32'(hz.flush_idex), 32'd0);
      chk({tag, ".rst.fwd_a"},      32'(hz.fwd_a),      32'd0);
      chk({tag, ".rst.fwd_b"},      32'(hz.fwd_b),      32'd0);
      chk({tag, ".rst.halted"},     32'(hz.halted),     32'd0);
      chk({tag, ".rst.stall_cnt"},  32'(hz.stall_cnt),  32'd0);
      chk({tag, ".rst.flush_cnt"},  32'(hz.flush_cnt),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      nop();
      model_reset();
      #1;
      do_reset("init");

      // add $3,$1,$2 ; add $4,$3,$3
      set_id(1, 2, 1, 1, 1, 3, 0, 0, 0, 0); run_cycle("t1a");
      set_id(3, 3, 1, 1, 1, 4, 0, 0, 0, 0); run_cycle("t1b");
      chk("t1.fwd_a", 32'(o_fa), 32'd1);
      chk("t1.fwd_b", 32'(o_fb), 32'd1);
      chk("t1.nostall", 32'(o_spc), 32'd0);

      // lw $5,0($1) ; add $6,$5,$0
      do_reset("t2");
      set_id(1, 0, 1, 0, 1, 5, 1, 0, 0, 0); run_cycle("t2a");
      set_id(5, 0, 1, 1, 1, 6, 0, 0, 0, 0); run_cycle("t2b");
      chk("t2.stall_pc", 32'(o_spc), 32'd1);
      chk("t2.stall_ifid", 32'(o_sif), 32'd1);
      chk("t2.flush_idex", 32'(o_fid), 32'd1);
      run_cycle("t2c");
      chk("t2.release", 32'(o_spc), 32'd0);
      chk("t2.fwd_mem", 32'(o_fa), 32'd2);
      chk("t2.stall_cnt", 32'(hz.stall_cnt), 32'd1);

      // $0 never forwards; youngest of two writers wins
      do_reset("t3");
      set_id(1, 2, 1, 1, 1, 0, 1, 0, 0, 0); run_cycle("t3a");
      set_id(0, 0, 1, 1, 1, 8, 0, 0, 0, 0); run_cycle("t3b");
      chk("t3.zero_fwd", 32'(o_fa), 32'd0);
      chk("t3.zero_nostall", 32'(o_spc), 32'd0);
      set_id(1, 2, 1, 1, 1, 7, 0, 0, 0, 0); run_cycle("t3c");
      set_id(1, 2, 1, 1, 1, 7, 0, 0, 0, 0); run_cycle("t3d");
      set_id(7, 7, 1, 1, 1, 9, 0, 0, 0, 0); run_cycle("t3e");
      chk("t3.youngest", 32'(o_fa), 32'd1);

      // taken branch on top of a load-use match
      do_reset("t4");
      set_id(1, 0, 1, 0, 1, 5, 1, 0, 0, 0); run_cycle("t4a");
      set_id(5, 0, 1, 0, 1, 6, 0, 0, 1, 0); run_cycle("t4b");
      chk("t4.flush_ifid", 32'(o_fif), 32'd1);
      chk("t4.flush_idex", 32'(o_fid), 32'd1);
      chk("t4.stall_pc", 32'(o_spc), 32'd0);
      chk("t4.flush_cnt", 32'(hz.flush_cnt), 32'd1);
      chk("t4.stall_cnt", 32'(hz.stall_cnt), 32'd0);

      // syscall drain, halt and resume
      do_reset("t5");
      set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle("t5sys");
      nop();
      for (int i = 0; i < 3; i++) begin
         run_cycle("t5drain");
         chk("t5.drain_halted", 32'(o_hlt), 32'd0);
         chk("t5.drain_hold", 32'(o_spc), 32'd1);
      end
      run_cycle("t5halt");
      chk("t5.halted", 32'(o_hlt), 32'd1);
      chk("t5.halt_hold", 32'(o_spc), 32'd1);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle("t5res");
      nop(); run_cycle("t5run");
      chk("t5.resumed", 32'(o_hlt), 32'd0);
      chk("t5.run_nohold", 32'(o_spc), 32'd0);

      // reset during DRAIN (with nonzero counters) and during a load-use stall
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); run_cycle("t6br");
      set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle("t6sys");
      nop(); run_cycle("t6drain");
      do_reset("t6d");
      set_id(1, 0, 1, 0, 1, 5, 1, 0, 0, 0); run_cycle("t6lw");
      set_id(5, 5, 1, 1, 1, 6, 0, 0, 0, 0);
      do_reset("t6l");
      run_cycle("t6after");
      chk("t6.no_stall", 32'(o_spc), 32'd0);

      // stall counter saturation
      for (int i = 0; i < CMAX + 10; i++) begin
         set_id(1, 0, 1, 0, 1, 5, 1, 0, 0, 0); run_cycle("satlw");
         set_id(5, 0, 1, 0, 1, 6, 0, 0, 0, 0); run_cycle("satuse");
      end
      chk("sat.stall_cnt", 32'(hz.stall_cnt), 32'(CMAX));

      // random traffic
      do_reset("rnd");
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 249) == 0) do_reset("rndrst");
         set_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0));
         run_cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
